disp_scan: RTL and testbench
============================

DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000: system clocks per refresh tick; legal range 2..2^20.
REQ-002 Parameter DWELL_TICKS, default 1000: refresh ticks per automatic channel step; legal range 1..2^16.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Din  input  16  channel word from the 8:1 channel multiplexer, selected by ADR.
REQ-006 BTN_NEXT  input  1  asynchronous, debounced step request; one step per rising edge.
REQ-007 AUTO  input  1  level; 1 enables automatic channel stepping.
REQ-008 ADR  output  3  channel select driven to the multiplexer.
REQ-009 AN  output  4  digit anodes, active-low, one-cold; AN[i] drives digit i, where digit 0 is the rightmost.
REQ-010 SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-011 Prescaler shall count 0..CLK_DIV-1 and wrap; tick shall be high for exactly one clk when the count equals CLK_DIV-1.
REQ-012 The 2-bit digit index shall increment on each tick, wrapping 3->0.
REQ-013 The snapshot register shall load Din on the tick where the digit index wraps 3->0, so all four digits of a frame come from one word.
REQ-014 Digit i shall show snapshot bits [4i+3:4i].
REQ-015 AN and SEG shall be registered; they shall reflect the new digit index and its nibble one clk after the tick.
REQ-016 Hex encoding shall be standard: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
REQ-017 BTN_NEXT shall pass through a 2-flop synchronizer and then a rising-edge detector; each detected edge shall increment ADR once.
REQ-018 While AUTO=1, the dwell counter shall count ticks; on reaching DWELL_TICKS-1 together with a tick, it shall clear and ADR shall increment.
REQ-019 While AUTO=0, the dwell counter shall be held at 0.
REQ-020 ADR shall wrap 7->0.
REQ-021 If a button edge and an auto step coincide, ADR shall increment by exactly 1 and the dwell counter shall clear.
REQ-022 A button edge shall clear the dwell counter, so the next auto step occurs a full dwell later.

Reset
REQ-023 While rst_n=0 the outputs shall be: ADR=0, AN=4'b1111, SEG=7'h7F.
REQ-024 While rst_n=0 the internal state shall be: prescaler=0, digit index=0, dwell counter=0, snapshot=0.
REQ-025 Synchronizer and edge-detector flops shall reset to 1, so a BTN_NEXT held high through reset release produces no step.
REQ-026 Reset asserted mid-frame shall take effect immediately; after release, the first tick shall occur at clk CLK_DIV after release.

Configuration
REQ-027 Macro DISP_SCAN_LZ_BLANK_EN defined: digit i (i=3..1) shall drive SEG=7'h7F, with AN still cycling, when snapshot nibbles i..3 are all zero; digit 0 shall never be blanked.
REQ-028 Macro DISP_SCAN_LZ_BLANK_EN undefined: no blanking; all four digits shall always show their nibble.

Verification
REQ-029 CLK_DIV=4, hold AUTO=0, release reset -> AN sequence 1110,1101,1011,0111,1110 with each value stable for 4 clk; ADR stays 0.
REQ-030 Din=16'h12AF, run one full frame -> digits 3..0 show SEG 0x79, 0x24, 0x08, 0x0E.
REQ-031 Din changes from 16'h1111 to 16'h2222 mid-frame -> the remaining digits of that frame still show 1; the next frame shows 2.
REQ-032 DWELL_TICKS=2, AUTO=1 -> ADR steps 0,1,...,7,0 every 8 clk (CLK_DIV=4); a BTN_NEXT pulse issued on a step cycle gives a single increment.
REQ-033 BTN_NEXT held high through reset release -> ADR=0; then 3 pulses -> ADR=3.
REQ-034 DISP_SCAN_LZ_BLANK_EN defined, Din=16'h0050 -> digits 3 and 2 show 0x7F, digit 1 shows 0x12, digit 0 shows 0x40; Din=16'h0000 -> only digit 0 lit, showing 0x40.

Source files
------------

// File: rtl/disp_scan.sv
// disp_scan: 4-digit multiplexed 7-segment scanner with channel stepping.
// A prescaler produces a refresh tick every CLK_DIV clocks. Each tick
// advances the digit index; a whole frame of four digits is drawn from one
// snapshot of Din taken when the index wraps. The channel select ADR steps
// on a synchronized BTN_NEXT rising edge, or automatically every
// DWELL_TICKS ticks while AUTO is high.
// Optional build macro: DISP_SCAN_LZ_BLANK_EN blanks leading-zero digits
// (digit 0 always lit).
module disp_scan #(
    parameter int CLK_DIV     = 50000,
    parameter int DWELL_TICKS = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Din,
    input  logic        BTN_NEXT,
    input  logic        AUTO,
    output logic [2:0]  ADR,
    output logic [3:0]  AN,
    output logic [6:0]  SEG
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DWELL_TICKS + 1);
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_TICKS - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   snap_q, snap_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    adr_q, adr_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;

    logic          tick;
    logic          btn_edge;
    logic          auto_step;
    logic [3:0]    nibble;

    // Active-low hex segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Refresh timing, frame snapshot and registered digit drive.
    always_comb begin
        tick    = (pre_q == PRE_MAX);
        pre_d   = tick ? '0 : pre_q + PW'(1);
        digit_d = tick ? digit_q + 2'd1 : digit_q;
        snap_d  = (tick && digit_q == 2'd3) ? Din : snap_q;
        nibble  = snap_q[{digit_q, 2'b00} +: 4];
        an_d    = ~(4'b0001 << digit_q);
        seg_d   = hex7(nibble);
`ifdef DISP_SCAN_LZ_BLANK_EN
        // Blank when this digit and every more significant one are zero.
        if (digit_q != 2'd0 && (snap_q >> {digit_q, 2'b00}) == 16'h0000)
            seg_d = 7'h7F;
`endif
    end

    // Button synchronizer, edge detect, dwell timer and channel select.
    always_comb begin
        sync1_d   = BTN_NEXT;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        btn_edge  = sync2_q & ~prev_q;
        auto_step = AUTO && tick && (dwell_q == DWELL_MAX);
        adr_d     = adr_q;
        if (btn_edge || auto_step)
            adr_d = adr_q + 3'd1;
        // Any step restarts the dwell so the next auto step is a full dwell away.
        dwell_d = dwell_q;
        if (!AUTO)
            dwell_d = '0;
        else if (btn_edge || auto_step)
            dwell_d = '0;
        else if (tick)
            dwell_d = dwell_q + DW'(1);
    end

    // State registers; synchronizer chain resets high so a held button is not a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            digit_q <= 2'd0;
            snap_q  <= 16'h0000;
            dwell_q <= '0;
            adr_q   <= 3'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            digit_q <= digit_d;
            snap_q  <= snap_d;
            dwell_q <= dwell_d;
            adr_q   <= adr_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign ADR = adr_q;
    assign AN  = an_q;
    assign SEG = seg_q;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: randomized bench for disp_scan with a behavioural model
// derived from edge counts since reset release.
module tb_disp_scan;

    localparam int CD = 4;
    localparam int DW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        btn;
    logic        auto_en;
    logic [2:0]  adr;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_errors = 0;

    disp_scan #(.CLK_DIV(CD), .DWELL_TICKS(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Din      (din),
        .BTN_NEXT (btn),
        .AUTO     (auto_en),
        .ADR      (adr),
        .AN       (an),
        .SEG      (seg)
    );

    // clock
    always #5 clk = ~clk;

    // reference model state
    int          e_cnt = 0;
    logic [15:0] hist[int];
    bit          btn_h[int];
    int          adr_m = 0;
    int          dwell_m = 0;
    logic [6:0]  hex_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e_cnt);
        end
    endtask

    function automatic bit btn_at(input int k);
        if (k < 1) return 1'b1;
        return btn_h[k];
    endfunction

    // digit shown after edge e counts CD-clock slots; the snapshot is the word
    // present at the last frame boundary before e
    function automatic logic [6:0] exp_seg(input int e);
        int d, m;
        logic [15:0] snap;
        logic [3:0]  nib;
        logic [6:0]  s;
        d = ((e - 1) / CD) % 4;
        m = ((e - 1) / (4 * CD)) * (4 * CD);
        snap = (m == 0) ? 16'h0000 : hist[m];
        nib = 4'((snap >> (4 * d)) & 16'h000F);
        s = hex_tab[nib];
`ifdef DISP_SCAN_LZ_BLANK_EN
        if (d != 0 && (snap >> (4 * d)) == 16'h0000) s = 7'h7F;
`endif
        return s;
    endfunction

    function automatic logic [3:0] exp_an(input int e);
        int d;
        logic [3:0] a;
        d = ((e - 1) / CD) % 4;
        a = 4'b1111;
        a[d] = 1'b0;
        return a;
    endfunction

    // model update on each rising edge: channel steps from button edges and dwell expiry
    always @(posedge clk) begin
        if (!rst_n) begin
            e_cnt = 0;
            adr_m = 0;
            dwell_m = 0;
            hist.delete();
            btn_h.delete();
        end else begin
            bit is_tick, b_step, a_step;
            e_cnt++;
            hist[e_cnt] = din;
            btn_h[e_cnt] = btn;
            is_tick = (e_cnt % CD) == 0;
            b_step = btn_at(e_cnt - 2) && !btn_at(e_cnt - 3);
            a_step = auto_en && is_tick && (dwell_m == DW - 1);
            if (b_step || a_step) adr_m = (adr_m + 1) % 8;
            if (!auto_en || b_step || a_step) dwell_m = 0;
            else if (is_tick) dwell_m++;
        end
    end

    // scoreboard: compare outputs away from the active edge
    always @(negedge clk) begin
        if (!rst_n || e_cnt == 0) begin
            check_eq("an_rst", 16'(an), 16'h000F);
            check_eq("seg_rst", 16'(seg), 16'h007F);
            check_eq("adr_rst", 16'(adr), 16'h0000);
        end else begin
            check_eq("an", 16'(an), 16'(exp_an(e_cnt)));
            check_eq("seg", 16'(seg), 16'(exp_seg(e_cnt)));
            check_eq("adr", 16'(adr), 16'(adr_m));
        end
    end

    // driver tasks
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_btn(input int hi, input int lo);
        btn = 1'b1;
        run(hi);
        btn = 1'b0;
        run(lo);
    endtask

    logic [15:0] din_tab[6] = '{16'h12AF, 16'h1111, 16'h2222, 16'h0050, 16'h0000, 16'h0A00};

    initial begin
        rst_n = 1'b0;
        din = 16'h0000;
        btn = 1'b0;
        auto_en = 1'b0;
        run(3);
        rst_n = 1'b1;

        // scanning with fixed and random words, AUTO off
        din = 16'h12AF;
        run(40);
        din = 16'h1111;
        run(38);
        din = 16'h2222;
        run(40);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0)
                din = ($urandom_range(0, 1) == 1) ? din_tab[$urandom_range(0, 5)]
                                                  : 16'($urandom);
            run(1);
        end

        // automatic stepping with random button pulses
        auto_en = 1'b1;
        run(80);
        for (int i = 0; i < 60; i++) begin
            din = 16'($urandom);
            pulse_btn($urandom_range(1, 8), $urandom_range(1, 10));
        end

        // random AUTO toggling
        for (int i = 0; i < 40; i++) begin
            auto_en = 1'($urandom_range(0, 1));
            din = din_tab[$urandom_range(0, 5)];
            pulse_btn($urandom_range(1, 6), $urandom_range(1, 20));
        end

        // asynchronous reset mid-frame with the button held high
        auto_en = 1'b0;
        btn = 1'b1;
        run(7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_an", 16'(an), 16'h000F);
        check_eq("async_seg", 16'(seg), 16'h007F);
        check_eq("async_adr", 16'(adr), 16'h0000);
        run(2);
        rst_n = 1'b1;
        run(10);
        @(posedge clk);
        #1;
        check_eq("held_btn_adr", 16'(adr), 16'h0000);
        @(negedge clk);
        btn = 1'b0;
        run(4);
        for (int i = 0; i < 3; i++) pulse_btn(3, 3);
        run(4);
        @(posedge clk);
        #1;
        check_eq("three_pulses_adr", 16'(adr), 16'h0003);
        run(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
